// File: rtl/queue_pkg.sv
// ---------------------------------------------------------------------------
// queue_pkg
//   Shared types and default sizes for the byte_queue stage that sits
//   downstream of the serial-to-byte deserializer.
//   Contents:
//     state_t        - enqueue handshake states (IDLE, ACK, WAIT_LOW)
//     DEFAULT_WIDTH  - default byte width in bits
//     DEFAULT_DEPTH  - default number of queue entries (power of two, >= 2)
// ---------------------------------------------------------------------------
package queue_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/byte_queue.sv
// ---------------------------------------------------------------------------
// byte_queue
//   Circular FIFO that accepts one byte per data_ready/ack handshake from the
//   deserializer and hands the oldest byte to a consumer on a dequeue strobe.
//   A full queue back-pressures upstream simply by not acknowledging.
//
//   Ports:
//     clk_100KHz  in   1      system clock, rising edge
//     reset       in   1      asynchronous, active-high
//     data_in     in   WIDTH  byte from deserializer, valid while enqueue_in=1
//     enqueue_in  in   1      deserializer data_ready level
//     ack_out     out  1      one-cycle pulse: byte captured
//     dequeue_in  in   1      consumer pop request, sampled every cycle
//     data_out    out  WIDTH  popped byte, registered, held until next pop
//     len_out     out  CW     current occupancy, 0..DEPTH
//     full_out    out  1      len_out == DEPTH
//     empty_out   out  1      len_out == 0
// ---------------------------------------------------------------------------
module byte_queue
  import queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk_100KHz,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           enqueue_in,
  output logic                           ack_out,
  input  logic                           dequeue_in,
  output logic [WIDTH-1:0]               data_out,
  output logic [$clog2(DEPTH+1)-1:0]     len_out,
  output logic                           full_out,
  output logic                           empty_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_len;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_dataOut;
  logic             w_write;
  logic             w_read;
  logic [CW-1:0]    w_lenNext;

  // A capture only happens from IDLE and is judged against the registered
  // full flag, so a pop in the same cycle cannot make room for it; the byte
  // is taken on the following cycle instead.
  always_comb begin
    w_nextState = r_state;
    w_write     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enqueue_in && !r_full) begin
          w_write     = 1'b1;
          w_nextState = ACK;
        end
      end
      ACK: begin
        w_nextState = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!enqueue_in) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Pops are ignored while empty, and the occupancy for the next cycle
  // accounts for a simultaneous capture and pop cancelling out.
  always_comb begin
    w_read    = dequeue_in && !r_empty;
    w_lenNext = r_len + CW'(w_write) - CW'(w_read);
  end

  // Handshake state register; reset abandons any handshake in flight.
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pointers, occupancy and flags move together on one edge, so the flags
  // always describe the same occupancy that len_out shows.
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_len     <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_dataOut <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_read) begin
        r_rdPtr   <= r_rdPtr + AW'(1);
        r_dataOut <= r_mem[r_rdPtr];
      end
      r_len   <= w_lenNext;
      r_full  <= (w_lenNext == CW'(DEPTH));
      r_empty <= (w_lenNext == '0);
    end
  end

  // Storage is deliberately left out of reset so it can map onto plain RAM;
  // a write and a read never hit the same entry because writes need a
  // non-full queue and reads a non-empty one.
  always_ff @(posedge clk_100KHz) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= data_in;
    end
  end

  assign ack_out   = (r_state == ACK);
  assign data_out  = r_dataOut;
  assign len_out   = r_len;
  assign full_out  = r_full;
  assign empty_out = r_empty;

endmodule

// File: tb/tb_byte_queue.sv
// ---------------------------------------------------------------------------
// tb_byte_queue
//   Self-checking bench for byte_queue. A behavioural model (a byte queue plus
//   a note of whether upstream is still locked out after an ack) predicts
//   every output each cycle; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_byte_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk_100KHz = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             enqueue_in;
  logic             ack_out;
  logic             dequeue_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    len_out;
  logic             full_out;
  logic             empty_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] mQueue [$];
  logic [WIDTH-1:0] mData;
  logic             mAck;
  logic             mLocked;

  byte_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .data_in    (data_in),
    .enqueue_in (enqueue_in),
    .ack_out    (ack_out),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .len_out    (len_out),
    .full_out   (full_out),
    .empty_out  (empty_out)
  );

  always #5 clk_100KHz = ~clk_100KHz;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mQueue.delete();
    mData   = '0;
    mAck    = 1'b0;
    mLocked = 1'b0;
  endtask

  // One rising edge of the model: a byte is taken when upstream offers it,
  // the queue is not full before any pop, and the previous handshake has
  // finished (ack shown and data_ready seen low afterwards).
  task automatic modelEdge();
    bit cap;
    bit pop;
    cap = !mLocked && enqueue_in && (mQueue.size() < DEPTH);
    pop = dequeue_in && (mQueue.size() > 0);
    mLocked = cap || mAck || (mLocked && enqueue_in);
    mAck    = cap;
    if (pop) mData = mQueue.pop_front();
    if (cap) mQueue.push_back(data_in);
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_ack"},   32'(ack_out),   32'(mAck));
    checkOutput({tag, "_len"},   32'(len_out),   32'(mQueue.size()));
    checkOutput({tag, "_full"},  32'(full_out),  32'(mQueue.size() == DEPTH));
    checkOutput({tag, "_empty"}, 32'(empty_out), 32'(mQueue.size() == 0));
    checkOutput({tag, "_data"},  32'(data_out),  32'(mData));
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic applyStimulus(input string tag, input logic enq,
                               input logic [WIDTH-1:0] din, input logic deq);
    enqueue_in = enq;
    data_in    = din;
    dequeue_in = deq;
    @(posedge clk_100KHz);
    modelEdge();
    @(negedge clk_100KHz);
    compareAll(tag);
  endtask

  task automatic pushByte(input string tag, input logic [WIDTH-1:0] b);
    applyStimulus(tag, 1'b1, b, 1'b0);
    applyStimulus(tag, 1'b1, b, 1'b0);
    applyStimulus(tag, 1'b0, b, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_ack", 32'(ack_out), 32'd0);
    checkOutput("rst_len", 32'(len_out), 32'd0);
    @(negedge clk_100KHz);
    compareAll("rst");
    reset = 1'b0;
  endtask

  initial begin
    int ackCount;
    reset      = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    data_in    = '0;
    modelReset();
    @(negedge clk_100KHz);
    doReset();

    // Held data_ready must yield exactly one capture
    ackCount = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("t1", 1'b1, 8'hA5, 1'b0);
      if (ack_out) ackCount++;
    end
    applyStimulus("t1", 1'b0, 8'h00, 1'b0);
    checkOutput("t1_ackcount", 32'(ackCount), 32'd1);
    checkOutput("t1_len1", 32'(len_out), 32'd1);

    // Pop it back
    applyStimulus("t2", 1'b0, 8'h00, 1'b1);
    checkOutput("t2_data", 32'(data_out), 32'hA5);
    checkOutput("t2_empty", 32'(empty_out), 32'd1);
    applyStimulus("t2", 1'b0, 8'h00, 1'b0);

    // Fill, then a refused byte that is accepted once a pop frees room
    for (int i = 1; i <= DEPTH; i++) pushByte("t3fill", 8'(i));
    checkOutput("t3_full", 32'(full_out), 32'd1);
    applyStimulus("t3hold", 1'b1, 8'h09, 1'b0);
    applyStimulus("t3hold", 1'b1, 8'h09, 1'b0);
    checkOutput("t3_noack", 32'(ack_out), 32'd0);
    applyStimulus("t3pop", 1'b1, 8'h09, 1'b1);
    checkOutput("t3_pop01", 32'(data_out), 32'h01);
    applyStimulus("t3take", 1'b1, 8'h09, 1'b0);
    checkOutput("t3_ack9", 32'(ack_out), 32'd1);
    checkOutput("t3_len8", 32'(len_out), 32'd8);
    applyStimulus("t3take", 1'b1, 8'h09, 1'b0);
    applyStimulus("t3take", 1'b0, 8'h09, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("t3drain", 1'b0, 8'h00, 1'b1);
    checkOutput("t3_last09", 32'(data_out), 32'h09);

    // Wrap-around of both pointers
    for (int i = 0; i < 6; i++) pushByte("t4a", 8'(8'h20 + i));
    for (int i = 0; i < 6; i++) applyStimulus("t4pop", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) pushByte("t4b", 8'(8'h40 + i));
    for (int i = 0; i < 6; i++) applyStimulus("t4pop", 1'b0, 8'h00, 1'b1);
    checkOutput("t4_last", 32'(data_out), 32'h45);

    // Simultaneous capture and pop leaves occupancy unchanged
    for (int i = 0; i < 3; i++) pushByte("t5fill", 8'(8'h60 + i));
    applyStimulus("t5both", 1'b1, 8'h77, 1'b1);
    checkOutput("t5_len3", 32'(len_out), 32'd3);
    checkOutput("t5_data", 32'(data_out), 32'h60);
    applyStimulus("t5", 1'b1, 8'h77, 1'b0);
    applyStimulus("t5", 1'b0, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("t5drain", 1'b0, 8'h00, 1'b1);

    // Pop while empty, then reset in the middle of an ack
    applyStimulus("t6empty", 1'b0, 8'h00, 1'b1);
    checkOutput("t6_hold", 32'(data_out), 32'h77);
    checkOutput("t6_len0", 32'(len_out), 32'd0);
    applyStimulus("t6cap", 1'b1, 8'hC3, 1'b0);
    checkOutput("t6_inack", 32'(ack_out), 32'd1);
    enqueue_in = 1'b0;
    doReset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 3) != 0), 8'($urandom),
                    ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
